exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Iterative multiply/divide unit in the EXE stage, consuming the post-forwarding rs/rt operands selected by the forward-unit muxes. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the EXE stage via a busy request. It presents the 64-bit result as HI/LO together with a done strobe, which travels down the pipeline as the HIWr/LOWr write.

## Interface
Parameters:
- none; iteration count MULDIV_ITER = 32 comes from the shared package.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- EXE_Flush  in  1  kills the in-flight operation (exception/redirect).
- EXE_Hold  in  1  downstream stall; EXE instruction may not advance this cycle.
- EXE_MulDivOp  in  3  MulDivOpType: MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- EXE_OperandA  in  32  forwarded rs value (multiplicand/dividend).
- EXE_OperandB  in  32  forwarded rt value (multiplier/divisor).
- EXE_MulDivBusy  out  1  stall request to hazard control; EXE stage must not advance.
- EXE_MulDivDone  out  1  HI/LO valid for the current EXE instruction.
- EXE_HI  out  32  high product / remainder.
- EXE_LO  out  32  low product / quotient.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + op≠MD_NOP + !EXE_Flush = start.
  - Capture operand magnitudes (absolute values for signed ops) and the result signs.
  - Load the counter with MULDIV_ITER.
  - Go to MUL or DIV.
- MUL: shift-add, one bit per cycle. DIV: restoring radix-2, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==1 go to DONE.
- DONE: HI/LO driven from the registered results with sign fixup applied.
  - Stay in DONE while EXE_Hold=1.
  - Go to IDLE when EXE_Hold=0; the instruction advances that cycle and is not restarted.
- EXE_MulDivBusy = (IDLE & start) | MUL | DIV, gated with !EXE_Flush.
- EXE_MulDivDone = 1 exactly in DONE.
- Signed rules:
  - Product is negated if the operand signs differ.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): HI = EXE_OperandA as captured, LO = 32'hFFFF_FFFF. Sign fixup is bypassed.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF yields LO=0x8000_0000, HI=0. No trap.
- EXE_Flush in any state: IDLE next cycle, no Done pulse, and Busy drops in the flush cycle itself.
- EXE_Hold has no effect in MUL/DIV; iteration continues.

## Timing
- Reset (async): state IDLE, counter 0. EXE_MulDivBusy=0, EXE_MulDivDone=0, EXE_HI=0, EXE_LO=0.
- Iterative op: Busy high for 33 cycles (start cycle plus 32 iterations). Done high on cycle 34 relative to the start cycle (cycle 1).
- EXE_HI/EXE_LO hold their last value outside DONE. They are stable throughout DONE, including while held.
- A new op may start in the cycle immediately after DONE→IDLE.
- rst mid-operation aborts immediately; there is no partial result.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full 64-bit product in the start cycle and go straight to DONE.
  - Busy lasts 1 cycle; Done is on cycle 2.
  - The MUL state is unused.
- MULDIV_FAST_MUL_EN undefined: iterative shift-add as above, 33-cycle busy.
- Division is always iterative.

## Structure
- Shared package (CPU_Defines): MulDivOpType enum, MULDIV_ITER constant, MulDivStateType enum.
- Sub-module muldiv_divcore: restoring-division datapath taking unsigned dividend/divisor, with start/step controls and raw quotient/remainder outputs. Sign fixup and divide-by-zero handling stay in exe_muldiv.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → Busy 33 cycles, then Done with HI=0xFFFF_FFFE, LO=0x0000_0001 (fast build: Busy 1 cycle).
- MULT 0xFFFF_FFFE (-2) × 3 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
- DIV -7 / 2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100 / 0 → HI=100, LO=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0, no Done glitch.
- DIVU 10/3 with EXE_Hold=1 for 5 cycles at DONE → Done stays high for 6 cycles with HI=1, LO=3 stable, then IDLE.
- EXE_Flush at iteration 10 of DIV → Busy drops in the same cycle, no Done. A following MULTU 2×3 starts next cycle → LO=6, HI=0. Async rst mid-MUL → all outputs 0 immediately.

Source files
------------

// File: rtl/CPU_Defines.sv
// Shared CPU definitions for the EXE-stage multiply/divide unit:
// operation and FSM state encodings, iteration count and a magnitude helper.
package CPU_Defines;

  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_CNT_W = 6;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } MulDivOpType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } MulDivStateType;

  // Absolute value for signed ops; unsigned ops pass the operand through.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// Restoring radix-2 division datapath on unsigned operands: one quotient bit
// per step. Sign handling and divide-by-zero are left to the caller.
module muldiv_divcore (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, quo_q, divisor_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic        diff_msb_unused;

  // Bring the next dividend bit into the partial remainder, then trial-subtract.
  assign shifted         = {rem_q, quo_q[31]};
  assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor_q};
  assign diff_msb_unused = diff[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= dividend;
      divisor_q <= divisor;
    end else if (step) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, whatever the statement order.
      rem_q <= borrow ? shifted[31:0] : diff[31:0];
      quo_q <= {quo_q[30:0], ~borrow};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage iterative MULT/MULTU/DIV/DIVU unit producing HI/LO with a done strobe.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; division stays iterative.
module exe_muldiv
  import CPU_Defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Flush,
  input  logic        EXE_Hold,
  input  logic [2:0]  EXE_MulDivOp,
  input  logic [31:0] EXE_OperandA,
  input  logic [31:0] EXE_OperandB,
  output logic        EXE_MulDivBusy,
  output logic        EXE_MulDivDone,
  output logic [31:0] EXE_HI,
  output logic [31:0] EXE_LO
);

  MulDivStateType state_q, state_d;
  MulDivOpType    op;
  logic [MULDIV_CNT_W-1:0] cnt_q;
  logic [63:0] prod_q;
  logic [31:0] a_raw_q, hi_q, lo_q;
  logic        neg_q, rem_neg_q, div0_q, is_div_q;
  logic        is_mul_op, is_div_op, is_signed, start;
  logic [31:0] mag_a, mag_b, quo_raw, rem_raw;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  assign op        = MulDivOpType'(EXE_MulDivOp);
  assign is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign start     = (state_q == IDLE) && (is_mul_op || is_div_op) && !EXE_Flush;
  assign mag_a     = mag32(EXE_OperandA, is_signed);
  assign mag_b     = mag32(EXE_OperandB, is_signed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    EXE_MulDivBusy = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        EXE_MulDivBusy = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        state_d = is_div_op ? DIV : DONE;
`else
        state_d = is_div_op ? DIV : MUL;
`endif
      end
      MUL, DIV: begin
        EXE_MulDivBusy = 1'b1;
        if (cnt_q == MULDIV_CNT_W'(1)) state_d = DONE;
      end
      DONE:    if (!EXE_Hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (EXE_Flush) begin
      state_d        = IDLE;
      EXE_MulDivBusy = 1'b0;
    end
  end

  assign EXE_MulDivDone = (state_q == DONE);

  muldiv_divcore u_divcore (
    .clk       (clk),
    .rst       (rst),
    .start     (start && is_div_op),
    .step      (state_q == DIV),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo_raw),
    .remainder (rem_raw)
  );

`ifndef MULDIV_FAST_MUL_EN
  logic [31:0] mcand_q;
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
`endif

  // NOTE: datapath registers are reset too, so a reset mid-operation leaves
  // no stale partial result observable on HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      a_raw_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= '0;
`endif
    end else if (EXE_Flush) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q     <= MULDIV_CNT_W'(MULDIV_ITER);
      a_raw_q   <= EXE_OperandA;
      neg_q     <= is_signed && (EXE_OperandA[31] ^ EXE_OperandB[31]);
      rem_neg_q <= is_signed && EXE_OperandA[31];
      div0_q    <= (EXE_OperandB == 32'd0);
      is_div_q  <= is_div_op;
`ifdef MULDIV_FAST_MUL_EN
      prod_q    <= 64'(mag_a) * 64'(mag_b);
`else
      prod_q    <= {32'd0, mag_b};
      mcand_q   <= mag_a;
`endif
    end else if (state_q == MUL || state_q == DIV) begin
      cnt_q <= cnt_q - MULDIV_CNT_W'(1);
`ifndef MULDIV_FAST_MUL_EN
      // Shift-add: conditionally add the multiplicand into the upper half, shift right.
      if (state_q == MUL)
        prod_q <= prod_q[0] ? {mul_sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};
`endif
    end
  end

  assign prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_raw_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_neg_q ? (~rem_raw + 32'd1) : rem_raw;
        res_lo = neg_q     ? (~quo_raw + 32'd1) : quo_raw;
      end
    end
  end

  // Capture the fixed-up result during DONE so HI/LO hold it afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == DONE) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign EXE_HI = (state_q == DONE) ? res_hi : hi_q;
  assign EXE_LO = (state_q == DONE) ? res_lo : lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: expected HI/LO queued at issue, compared at Done,
// plus busy/done timing, hold, flush and asynchronous reset behaviour.
module tb_exe_muldiv;
  import CPU_Defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_Flush, EXE_Hold;
  logic [2:0]  EXE_MulDivOp;
  logic [31:0] EXE_OperandA, EXE_OperandB;
  logic        EXE_MulDivBusy, EXE_MulDivDone;
  logic [31:0] EXE_HI, EXE_LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  always #5 clk = ~clk;

  exe_muldiv dut (
    .clk            (clk),
    .rst            (rst),
    .EXE_Flush      (EXE_Flush),
    .EXE_Hold       (EXE_Hold),
    .EXE_MulDivOp   (EXE_MulDivOp),
    .EXE_OperandA   (EXE_OperandA),
    .EXE_OperandB   (EXE_OperandB),
    .EXE_MulDivBusy (EXE_MulDivBusy),
    .EXE_MulDivDone (EXE_MulDivDone),
    .EXE_HI         (EXE_HI),
    .EXE_LO         (EXE_LO)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic result_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    int ia, ib;
    p = '0;
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0)                                p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          ia = int'(a);
          ib = int'(b);
          p  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      MD_DIVU: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: p = '0;
    endcase
    return p;
  endfunction

  // Caller is positioned just after a falling edge; the op issues in this cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold_n);
    int busy_cnt, done_cyc, done_cnt, exp_busy;
    logic stable;
    result_t exp;
    busy_cnt = 0;
    done_cyc = 0;
    exp_busy = (op == MD_DIV || op == MD_DIVU) ? DIV_BUSY : MUL_BUSY;
    EXE_MulDivOp = op;
    EXE_OperandA = a;
    EXE_OperandB = b;
    EXE_Hold     = (hold_n > 0);
    exp_q.push_back(model(op, a, b));
    for (int cyc = 1; cyc <= 100; cyc++) begin
      #1;
      if (EXE_MulDivBusy) busy_cnt++;
      if (EXE_MulDivDone) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      EXE_MulDivOp = MD_NOP;
    end
    EXE_MulDivOp = MD_NOP;
    exp = exp_q.pop_front();
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_busy + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    if (done_cyc == 0) return;
    check({tag, " hi_lo"}, {EXE_HI, EXE_LO}, exp);
    done_cnt = 1;
    stable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      EXE_Hold = (done_cnt <= hold_n);
      @(negedge clk);
      #1;
      if (!EXE_MulDivDone) break;
      done_cnt++;
      if ({EXE_HI, EXE_LO} !== exp) stable = 1'b0;
    end
    EXE_Hold = 1'b0;
    check({tag, " done_len"}, 64'(done_cnt), 64'(hold_n + 1));
    if (hold_n > 0) check({tag, " stable_in_hold"}, 64'(stable), 64'd1);
    check({tag, " held_after"}, {EXE_HI, EXE_LO}, exp);
  endtask

  initial begin
    rst          = 1'b1;
    EXE_Flush    = 1'b0;
    EXE_Hold     = 1'b0;
    EXE_MulDivOp = MD_NOP;
    EXE_OperandA = '0;
    EXE_OperandB = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy_done", {62'd0, EXE_MulDivBusy, EXE_MulDivDone}, 64'd0);
    check("reset hi_lo", {EXE_HI, EXE_LO}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_zero", MD_DIVU,  32'd100, 32'd0, 0);
    run_op("div_zero",  MD_DIV,   32'hFFFF_FF00, 32'd0, 0);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_hold", MD_DIVU,  32'd10, 32'd3, 5);
    run_op("div_rem",   MD_DIV,   32'd7, 32'hFFFF_FFFE, 0);

    // Flush a DIV at its 10th iteration: Busy drops in that cycle, no Done follows.
    EXE_MulDivOp = MD_DIV;
    EXE_OperandA = 32'd1000;
    EXE_OperandB = 32'd7;
    for (int cyc = 2; cyc <= 11; cyc++) begin
      @(negedge clk);
      EXE_MulDivOp = MD_NOP;
    end
    EXE_Flush = 1'b1;
    #1;
    check("flush busy_drop", {62'd0, EXE_MulDivBusy, EXE_MulDivDone}, 64'd0);
    @(negedge clk);
    EXE_Flush = 1'b0;
    #1;
    check("flush idle", {62'd0, EXE_MulDivBusy, EXE_MulDivDone}, 64'd0);
    run_op("multu_after_flush", MD_MULTU, 32'd2, 32'd3, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) rb = ~rb + 32'd1;
      run_op($sformatf("rand%0d", i), rop, ra, rb, i % 3);
    end

    // Asynchronous reset mid-operation clears everything without waiting for a clock edge.
    run_op("multu_pre_rst", MD_MULTU, 32'd2, 32'd3, 0);
    EXE_MulDivOp = MD_MULTU;
    EXE_OperandA = 32'h1234_5678;
    EXE_OperandB = 32'h9ABC_DEF0;
    repeat (5) begin
      @(negedge clk);
      EXE_MulDivOp = MD_NOP;
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid busy_done", {62'd0, EXE_MulDivBusy, EXE_MulDivDone}, 64'd0);
    check("rst_mid hi_lo", {EXE_HI, EXE_LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst idle", {62'd0, EXE_MulDivBusy, EXE_MulDivDone}, 64'd0);
    run_op("div_after_rst", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
